// File: rtl/serial_magnitude_comparator.sv
// Digit-serial MSB-first magnitude comparator with valid/ready handshakes.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN finishes as soon as a digit differs.
module serial_magnitude_comparator #(
    parameter int unsigned N     = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         signed_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         lesser,
    output logic         greater,
    output logic         equal,
    output logic         busy
);

    localparam int unsigned K  = (DIGIT > 0) ? N / DIGIT : 1;
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};

    if (DIGIT < 1 || N < 2) begin : g_bad_width
        $error("serial_magnitude_comparator: need N >= 2 and DIGIT >= 1");
    end else if ((N % DIGIT) != 0) begin : g_bad_digit
        $error("serial_magnitude_comparator: N must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            decided_q, decided_d;
    logic            lesser_q, lesser_d, greater_q, greater_d, equal_q, equal_d;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic            last, differ;

    assign a_dig  = a_sh_q[N-1 -: DIGIT];
    assign b_dig  = b_sh_q[N-1 -: DIGIT];
    assign last   = (cnt_q == CW'(K - 1));
    assign differ = !decided_q && (a_dig != b_dig);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = StCmp;
            StCmp: begin
                if (last) begin
                    state_d = StDone;
                end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                else if (differ) begin
                    state_d = StDone;
                end
`endif
            end
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StCmp);
        out_valid = (state_q == StDone);
    end

    always_comb begin
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        lesser_d  = lesser_q;
        greater_d = greater_q;
        equal_d   = equal_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Flipping both sign bits maps two's-complement order onto unsigned order.
                    a_sh_d    = a ^ (signed_mode ? MSB : '0);
                    b_sh_d    = b ^ (signed_mode ? MSB : '0);
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    lesser_d  = 1'b0;
                    greater_d = 1'b0;
                    equal_d   = 1'b0;
                end
            end
            StCmp: begin
                a_sh_d = a_sh_q << DIGIT;
                b_sh_d = b_sh_q << DIGIT;
                cnt_d  = cnt_q + 1'b1;
                if (differ) begin
                    decided_d = 1'b1;
                    greater_d = (a_dig > b_dig);
                    lesser_d  = (a_dig < b_dig);
                end else if (last && !decided_q) begin
                    equal_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            lesser_q  <= 1'b0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
        end else begin
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            lesser_q  <= lesser_d;
            greater_q <= greater_d;
            equal_q   <= equal_d;
        end
    end

    assign lesser  = lesser_q;
    assign greater = greater_q;
    assign equal   = equal_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomized self-checking bench: unit 0 is N=8/DIGIT=1, unit 1 is N=8/DIGIT=4.
module tb_serial_magnitude_comparator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] in_valid, out_ready, sm;
    logic [7:0] a_s [2];
    logic [7:0] b_s [2];
    wire  [1:0] in_ready, out_valid, lesser, greater, equal, busy;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.N(8), .DIGIT(1)) u_dig1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_s[0]), .b(b_s[0]), .signed_mode(sm[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .lesser(lesser[0]), .greater(greater[0]),
        .equal(equal[0]), .busy(busy[0])
    );

    serial_magnitude_comparator #(.N(8), .DIGIT(4)) u_dig4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_s[1]), .b(b_s[1]), .signed_mode(sm[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .lesser(lesser[1]), .greater(greater[1]),
        .equal(equal[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {lesser, greater, equal} from plain integer comparison.
    function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic s);
        int ia, ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        if (ia < ib) return 3'b100;
        if (ia > ib) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int exp_lat(input int u, input logic [7:0] a, input logic [7:0] b);
        int dig;
        int k;
        dig = (u == 0) ? 1 : 4;
        k   = 8 / dig;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (a != b) begin
            logic [7:0] x;
            int p;
            x = a ^ b;
            p = 7;
            while (p > 0 && !x[p]) p--;
            return (7 - p) / dig + 1;
        end
`endif
        return k + 0 * int'(a ^ b);
    endfunction

    // Called at a negedge with in_valid low; returns at a negedge with in_valid low.
    task automatic op(input int u, input logic [7:0] a, input logic [7:0] b, input logic s,
                      input int hold);
        int lat;
        logic [2:0] exp;
        exp = model(a, b, s);
        check("in_ready_idle", 32'(in_ready[u]), 32'd1);
        a_s[u] = a;
        b_s[u] = b;
        sm[u] = s;
        in_valid[u] = 1'b1;
        @(negedge clk);
        in_valid[u] = 1'b0;
        a_s[u] = 8'($urandom);
        b_s[u] = 8'($urandom);
        sm[u] = 1'($urandom);
        lat = 0;
        while (!out_valid[u] && lat < 40) begin
            check("busy_cmp", {30'd0, busy[u], in_ready[u]}, 32'b10);
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat(u, a, b)));
        check("result", {29'd0, lesser[u], greater[u], equal[u]}, {29'd0, exp});
        repeat (hold) begin
            in_valid[u] = 1'b1;
            a_s[u] = 8'($urandom);
            b_s[u] = 8'($urandom);
            @(negedge clk);
            check("hold", {26'd0, out_valid[u], in_ready[u], busy[u], lesser[u], greater[u],
                  equal[u]}, {26'd0, 3'b100, exp});
        end
        in_valid[u] = 1'b1;
        out_ready[u] = 1'b1;
        @(negedge clk);
        check("release", {26'd0, out_valid[u], in_ready[u], busy[u], lesser[u], greater[u],
              equal[u]}, {26'd0, 3'b010, exp});
        in_valid[u] = 1'b0;
        out_ready[u] = 1'b0;
    endtask

    initial begin
        in_valid = '0;
        out_ready = '0;
        sm = '0;
        a_s[0] = '0; a_s[1] = '0;
        b_s[0] = '0; b_s[1] = '0;
        #1;
        for (int u = 0; u < 2; u++) begin
            check("reset_state", {26'd0, out_valid[u], in_ready[u], busy[u], lesser[u],
                  greater[u], equal[u]}, 32'b010000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        op(0, 8'h5A, 8'h5A, 1'b0, 0);
        op(0, 8'hFF, 8'h01, 1'b1, 0);
        op(0, 8'hFF, 8'h01, 1'b0, 0);
        op(0, 8'h80, 8'h00, 1'b0, 0);
        op(0, 8'hAB, 8'hCD, 1'b0, 5);

        // Asynchronous reset during the third CMP cycle of a deciding operation.
        a_s[0] = 8'h80;
        b_s[0] = 8'h00;
        sm[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort", {26'd0, out_valid[0], in_ready[0], busy[0], lesser[0], greater[0],
                 equal[0]}, 32'b010000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op(0, 8'h10, 8'h20, 1'b0, 1);

        op(1, 8'h3C, 8'h3D, 1'b0, 0);
        op(1, 8'h3C, 8'h3C, 1'b0, 2);
        op(1, 8'h7F, 8'h80, 1'b1, 0);

        for (int i = 0; i < 60; i++) begin
            int u;
            logic [7:0] ra, rb;
            u = int'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rb = ra;
            op(u, ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
